// File: rtl/count_seq_if.sv
// Bus between a count stream source and the sequence checker: strobe, count
// value and error-clear in, lock/error status out.
interface count_seq_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) ();
    logic             en;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] last_val;
    logic [1:0]       state;

    modport master (
        output en, din, clr_err,
        input  locked, err_pulse, err_count, last_val, state
    );

    modport slave (
        input  en, din, clr_err,
        output locked, err_pulse, err_count, last_val, state
    );
endinterface

// File: rtl/count_seq_checker.sv
// Receive-side checker for a free-running up-counter: synchronises the sampled
// bus, tracks lock on +1 increments and counts mismatches seen while locked.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    count_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        ACQ    = 2'b01,
        LOCKED = 2'b10
    } state_e;

    localparam logic [3:0]       LOCK_TH = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_TH = 4'(LOSS_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic             s1_en_q, s2_en_q;
    logic [WIDTH-1:0] s1_din_q, s2_din_q;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] inc_s;
    logic             match_s;
    logic [3:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    state_e           state_q, state_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0] last_val_q, last_val_d;

    assign inc_s   = prev_q + WIDTH'(1);
    assign match_s = (s2_din_q == inc_s);

    // Next-state computation for the checker FSM and its registered outputs.
    always_comb begin
        prev_d      = prev_q;
        last_val_d  = last_val_q;
        good_d      = good_q;
        bad_d       = bad_q;
        state_d     = state_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        // Clear is applied before any increment in the same cycle.
        err_count_d = bus.clr_err ? {ERR_W{1'b0}} : err_count_q;
        if (s2_en_q) begin
            prev_d     = s2_din_q;
            last_val_d = s2_din_q;
            case (state_q)
                HUNT: begin
                    state_d = ACQ;
                    good_d  = 4'd0;
                end
                ACQ: begin
                    if (!match_s) begin
                        good_d = 4'd0;
                    end else if (good_q + 4'd1 >= LOCK_TH) begin
                        state_d  = LOCKED;
                        good_d   = 4'd0;
                        bad_d    = 4'd0;
                        locked_d = 1'b1;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end
                LOCKED: begin
                    if (match_s) begin
                        bad_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_d != ERR_MAX) begin
                            err_count_d = err_count_d + ERR_W'(1);
                        end else begin
                            err_count_d = ERR_MAX;
                        end
                        if (bad_q + 4'd1 >= LOSS_TH) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            bad_d    = 4'd0;
                        end else begin
                            bad_d = bad_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                    good_d   = 4'd0;
                    bad_d    = 4'd0;
                end
            endcase
        end else begin
            prev_d = prev_q;
        end
    end

    // Two-stage input synchroniser plus all checker state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_en_q     <= 1'b0;
            s1_din_q    <= {WIDTH{1'b0}};
            s2_en_q     <= 1'b0;
            s2_din_q    <= {WIDTH{1'b0}};
            prev_q      <= {WIDTH{1'b0}};
            good_q      <= 4'd0;
            bad_q       <= 4'd0;
            state_q     <= HUNT;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= {ERR_W{1'b0}};
            last_val_q  <= {WIDTH{1'b0}};
        end else begin
            s1_en_q     <= bus.en;
            s1_din_q    <= bus.din;
            s2_en_q     <= s1_en_q;
            s2_din_q    <= s1_din_q;
            prev_q      <= prev_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            state_q     <= state_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            last_val_q  <= last_val_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.last_val  = last_val_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench: one checker with the default error width and one with a
// 2-bit error counter, both fed the same stream.
module tb_count_seq_checker;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   pa = 0;
    int   pb = 0;
    int   pa0, pb0;
    int   cur;

    count_seq_if #(.WIDTH(4), .ERR_W(8)) ifa ();
    count_seq_if #(.WIDTH(4), .ERR_W(2)) ifb ();

    assign ifb.en      = ifa.en;
    assign ifb.din     = ifa.din;
    assign ifb.clr_err = ifa.clr_err;

    count_seq_checker #(.WIDTH(4), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    count_seq_checker #(.WIDTH(4), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    // Pulse counters; each one-cycle pulse is seen at exactly one edge.
    always @(posedge clk) begin
        if (ifa.err_pulse === 1'b1) pa <= pa + 1;
        if (ifb.err_pulse === 1'b1) pb <= pb + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic e, input logic [3:0] v, input logic c);
        ifa.en      = e;
        ifa.din     = v;
        ifa.clr_err = c;
        @(negedge clk);
    endtask

    task automatic flush();
        repeat (3) put(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        logic [3:0] glitch [6];
        int         gaps [5];
        glitch = '{4'd5, 4'd6, 4'd7, 4'd3, 4'd4, 4'd5};
        gaps   = '{0, 1, 3, 2, 0};

        rst_n       = 1'b0;
        ifa.en      = 1'b0;
        ifa.din     = 4'd0;
        ifa.clr_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_state", 32'(ifa.state), 32'd0);
        chk("rst_locked", 32'(ifa.locked), 32'd0);
        chk("rst_errcnt", 32'(ifa.err_count), 32'd0);

        // Clean lock and two wraps, back-to-back samples
        pa0 = pa;
        for (int i = 0; i < 40; i++) begin
            put(1'b1, 4'(i), 1'b0);
            if (i == 1) chk("a_state_hunt", 32'(ifa.state), 32'd0);
            if (i == 2) chk("a_state_acq", 32'(ifa.state), 32'd1);
            if (i == 5) chk("a_not_locked", 32'(ifa.locked), 32'd0);
            if (i == 6) chk("a_locked", 32'(ifa.locked), 32'd1);
        end
        flush();
        chk("a_pulses", 32'(pa - pa0), 32'd0);
        chk("a_errcnt", 32'(ifa.err_count), 32'd0);
        chk("a_state_lock", 32'(ifa.state), 32'd2);
        chk("a_last", 32'(ifa.last_val), 32'd7);

        // Single glitch while locked
        for (int i = 8; i < 21; i++) put(1'b1, 4'(i), 1'b0);
        pa0 = pa;
        for (int i = 0; i < 6; i++) put(1'b1, glitch[i], 1'b0);
        flush();
        chk("g_pulses", 32'(pa - pa0), 32'd1);
        chk("g_errcnt", 32'(ifa.err_count), 32'd1);
        chk("g_errcnt_b", 32'(ifb.err_count), 32'd1);
        chk("g_locked", 32'(ifa.locked), 32'd1);
        chk("g_last", 32'(ifa.last_val), 32'd5);

        // Clear, then loss of lock with four repeats
        put(1'b0, 4'd0, 1'b1);
        flush();
        chk("c_clr_a", 32'(ifa.err_count), 32'd0);
        chk("c_clr_b", 32'(ifb.err_count), 32'd0);
        pa0 = pa;
        repeat (3) put(1'b1, 4'd9, 1'b0);
        flush();
        chk("l_pulses", 32'(pa - pa0), 32'd3);
        chk("l_errcnt", 32'(ifa.err_count), 32'd3);
        chk("l_locked", 32'(ifa.locked), 32'd0);
        chk("l_state", 32'(ifa.state), 32'd0);
        put(1'b1, 4'd9, 1'b0);
        flush();
        chk("l_state_acq", 32'(ifa.state), 32'd1);
        chk("l_pulses4", 32'(pa - pa0), 32'd3);

        // Saturation on the 2-bit counter, lock held between mismatches
        put(1'b0, 4'd0, 1'b1);
        for (int i = 10; i < 14; i++) put(1'b1, 4'(i), 1'b0);
        flush();
        chk("s_locked", 32'(ifb.locked), 32'd1);
        chk("s_errcnt0", 32'(ifb.err_count), 32'd0);
        cur = 13;
        pa0 = pa;
        pb0 = pb;
        for (int k = 0; k < 5; k++) begin
            put(1'b1, 4'(cur + 5), 1'b0);
            put(1'b1, 4'(cur + 6), 1'b0);
            cur = cur + 6;
        end
        flush();
        chk("s_errcnt_b", 32'(ifb.err_count), 32'd3);
        chk("s_errcnt_a", 32'(ifa.err_count), 32'd5);
        chk("s_pulses_b", 32'(pb - pb0), 32'd5);
        chk("s_pulses_a", 32'(pa - pa0), 32'd5);
        chk("s_locked_b", 32'(ifb.locked), 32'd1);
        put(1'b1, 4'(cur + 5), 1'b0);
        put(1'b0, 4'd0, 1'b0);
        put(1'b0, 4'd0, 1'b1);
        flush();
        chk("s_clrinc_b", 32'(ifb.err_count), 32'd1);
        chk("s_clrinc_a", 32'(ifa.err_count), 32'd1);

        // Asynchronous reset mid-cycle with random inputs
        ifa.en  = 1'b1;
        ifa.din = 4'($urandom_range(0, 15));
        #2 rst_n = 1'b0;
        #1;
        chk("r_locked", 32'(ifa.locked), 32'd0);
        chk("r_pulse", 32'(ifa.err_pulse), 32'd0);
        chk("r_errcnt", 32'(ifa.err_count), 32'd0);
        chk("r_last", 32'(ifa.last_val), 32'd0);
        chk("r_state", 32'(ifa.state), 32'd0);
        chk("r_errcnt_b", 32'(ifb.err_count), 32'd0);
        ifa.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Strobe gaps do not break the sequence
        pa0 = pa;
        for (int i = 0; i < 5; i++) begin
            put(1'b1, 4'(2 + i), 1'b0);
            repeat (gaps[i]) put(1'b0, 4'd0, 1'b0);
        end
        flush();
        chk("gap_locked", 32'(ifa.locked), 32'd1);
        chk("gap_pulses", 32'(pa - pa0), 32'd0);
        chk("gap_errcnt", 32'(ifa.err_count), 32'd0);
        chk("gap_last", 32'(ifa.last_val), 32'd6);

        // One-cycle reset mid-lock, then relock from fresh history
        rst_n = 1'b0;
        put(1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
        chk("rl_unlocked", 32'(ifa.locked), 32'd0);
        for (int i = 11; i < 16; i++) put(1'b1, 4'(i), 1'b0);
        flush();
        chk("rl_locked", 32'(ifa.locked), 32'd1);
        chk("rl_errcnt", 32'(ifa.err_count), 32'd0);
        chk("rl_last", 32'(ifa.last_val), 32'd15);
        chk("rl_state", 32'(ifa.state), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive-side checker for the free-running WIDTH-bit up-counter that our counter tiles drive onto output pins.
- Samples an externally supplied count bus and verifies that every new sample equals the previous sample + 1, modulo 2^WIDTH.
- Reports lock status, a per-error pulse and a saturating error count.
- Sits behind the input pins in a top-level wrapper, so the count and strobe pass through a 2-flop synchroniser before checking.

Parameters:
- WIDTH, 4, width of the count bus under test.
- LOCK_CNT, 4, number of consecutive correct increments needed to declare lock (legal range 1..15).
- LOSS_CNT, 3, number of consecutive mismatches while locked that drop lock (legal range 1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; assert asynchronously, release synchronously in the wrapper.
- en  input  1  sample strobe; din is valid when en=1 (asynchronous to clk, synchronised inside).
- din  input  WIDTH  count value under test.
- clr_err  input  1  synchronous clear of err_count; already in the clk domain.
- locked  output  1  1 while in the LOCKED state.
- err_pulse  output  1  one-cycle pulse per mismatch detected while LOCKED.
- err_count  output  ERR_W  saturating mismatch count.
- last_val  output  WIDTH  most recent accepted sample.
- state  output  2  encoded state: 00 HUNT, 01 ACQ, 10 LOCKED; 11 is unused.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following clear to 0 immediately:
  - synchroniser flops, prev, good_cnt, bad_cnt;
  - locked, err_pulse, err_count, last_val;
  - state returns to HUNT.
- Reset mid-stream discards all history. After release the checker re-hunts from the next sample.
- Input path:
  - {en, din} pass through two register stages: s1 then s2.
  - A sample is "valid" in the cycle s2.en=1.
  - Outputs reflect that sample after the next edge.
  - Total latency is 3 rising edges from the capture edge (the capture edge counts as edge 1).
- Every en=1 cycle is a separate sample. en=0 cycles are ignored and do not break the sequence.
- Expected value = prev + 1, truncated to WIDTH. WIDTH=4: 15 -> 0 is a correct increment. A repeated value is a mismatch.
- On every valid sample, in any state: prev <= sample and last_val <= sample. The checker always resynchronises to the actual value.
- HUNT:
  - Valid sample -> ACQ, good_cnt <= 0.
  - No error reporting.
- ACQ:
  - Match: good_cnt++. When good_cnt reaches LOCK_CNT -> LOCKED, bad_cnt <= 0, locked <= 1.
  - Mismatch: good_cnt <= 0, stay in ACQ.
  - No error reporting.
- LOCKED:
  - Match: bad_cnt <= 0.
  - Mismatch:
    - err_pulse <= 1 for exactly one cycle;
    - err_count increments, saturating at 2^ERR_W-1;
    - bad_cnt++.
  - When bad_cnt reaches LOSS_CNT: -> HUNT, locked <= 0 in the same update. The error that caused loss of lock is still counted and pulsed.
- err_pulse is 0 in every cycle without a LOCKED mismatch.
- clr_err:
  - clr_err=1 sets err_count to 0 on the next edge.
  - If a counted mismatch occurs in the same cycle, err_count <= 1. The clear applies first, then the increment.
  - clr_err affects nothing else.
- Saturation: at max value, further errors still pulse err_pulse, but err_count holds its value.
- Back-to-back samples (en=1 every cycle) are fully supported. There is no throughput limit.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with random inputs -> all outputs are 0 and state=00 immediately, with no clock edge required.
- Clean lock and wrap: default params, en=1 every cycle, din=0,1,2,...,15,0,1,... ->
  - state goes 00 -> 01 after sample 0;
  - locked=1 after sample 4 is processed (3 edges after capture);
  - the 15 -> 0 wrap gives no err_pulse;
  - err_count stays 0 for 40 samples.
- Single glitch while locked: stream 5,6,7,3,4,5 ->
  - exactly one err_pulse, for sample 3;
  - err_count=1, locked stays 1, last_val=5 at the end.
- Loss of lock: locked, then samples 9,9,9,9 ->
  - three err_pulses, err_count=3;
  - locked=0 and state=00 after the third mismatch;
  - the 4th sample moves the checker to ACQ with no pulse.
- Saturation and clear: ERR_W=2, locked, 5 mismatches interleaved with good samples so lock is held ->
  - err_count saturates at 3;
  - 5 err_pulses are seen.
  - Then assert clr_err in the same cycle as a mismatch -> err_count=1.
- Strobe gaps and reset mid-lock:
  - din 2,3,4,5,6 with en=0 gaps of 0-3 cycles between samples -> lock with no errors.
  - Then pulse rst_n low for 1 cycle -> locked=0.
  - Next samples 11,12,13,14,15 -> re-lock with err_count=0.
